// File: rtl/puf_crp_engine_if.sv
// PUF link: challenge/fire from the acquisition engine, settled response bit back.
interface puf_crp_engine_if;
  logic [63:0] puf_challenge;
  logic        puf_fire;
  logic        puf_resp;

  modport master (output puf_challenge, output puf_fire, input puf_resp);
  modport slave  (input puf_challenge, input puf_fire, output puf_resp);
endinterface

// File: rtl/puf_crp_engine.sv
// Challenge-response acquisition: LFSR challenges, fire/settle/sample per vote,
// majority-voted bits shifted into a response word.
module puf_crp_engine #(
  parameter int RESP_W     = 64,
  parameter int SETTLE_CYC = 16,
  parameter int VOTES      = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [63:0]        seed,
  puf_crp_engine_if.master   puf,
  output logic               busy,
  output logic               done,
  output logic [63:0]        response,
  output logic [6:0]         bit_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FIRE, S_SETTLE, S_SAMPLE, S_NEXT, S_DONE
  } state_t;

  localparam int          SW          = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [3:0]  VOTES_L     = 4'(VOTES);
  localparam logic [3:0]  HALF_L      = 4'(VOTES / 2);
  localparam logic [6:0]  RESP_W_L    = 7'(RESP_W);

  state_t          state;
  logic [63:0]     lfsr;
  logic [3:0]      vote_cnt;
  logic [3:0]      ones;
  logic [SW-1:0]   settle_cnt;
  logic            fire_q;
  logic            fb;
  logic            vote_bit;

  assign fb       = lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59];
  assign vote_bit = (ones > HALF_L);

  assign puf.puf_challenge = lfsr;
  assign puf.puf_fire      = fire_q;

  // Outputs are registered: each transition sets the value the target state shows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      lfsr       <= '0;
      vote_cnt   <= '0;
      ones       <= '0;
      settle_cnt <= '0;
      fire_q     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      response   <= '0;
      bit_count  <= '0;
    end else begin
      fire_q <= 1'b0;
      done   <= 1'b0;
      if (abort && state != S_IDLE) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state <= S_LOAD;
              busy  <= 1'b1;
            end
          end
          S_LOAD: begin
            lfsr      <= (seed == '0) ? 64'h1 : seed;
            response  <= '0;
            bit_count <= '0;
            vote_cnt  <= '0;
            ones      <= '0;
            state     <= S_FIRE;
            fire_q    <= 1'b1;
          end
          S_FIRE: begin
            settle_cnt <= '0;
            if (SETTLE_CYC > 0) state <= S_SETTLE;
            else                state <= S_SAMPLE;
          end
          S_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) state <= S_SAMPLE;
            else                           settle_cnt <= settle_cnt + 1'b1;
          end
          S_SAMPLE: begin
            ones     <= ones + {3'b000, puf.puf_resp};
            vote_cnt <= vote_cnt + 4'd1;
            if (vote_cnt + 4'd1 < VOTES_L) begin
              state  <= S_FIRE;
              fire_q <= 1'b1;
            end else begin
              state <= S_NEXT;
            end
          end
          S_NEXT: begin
            response  <= {response[62:0], vote_bit};
            bit_count <= bit_count + 7'd1;
            lfsr      <= {lfsr[62:0], fb};
            vote_cnt  <= '0;
            ones      <= '0;
            if (bit_count + 7'd1 == RESP_W_L) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state  <= S_FIRE;
              fire_q <= 1'b1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_puf_crp_engine.sv
// Bench for puf_crp_engine: default instance plus a small RESP_W=4/VOTES=1/SETTLE_CYC=0 instance.
module tb_puf_crp_engine;

  localparam int NV = 5;
  localparam int FULL_LAT = 2 + 64 * (NV * (16 + 2) + 1);
  localparam logic [63:0] TAPS = (64'h1 << 63) | (64'h1 << 62) | (64'h1 << 60) | (64'h1 << 59);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, abort_a, start_b, abort_b;
  logic [63:0] seed_a, seed_b;
  logic        busy_a, done_a, busy_b, done_b;
  logic [63:0] resp_a, resp_b;
  logic [6:0]  bc_a, bc_b;

  puf_crp_engine_if pa ();
  puf_crp_engine_if pb ();

  puf_crp_engine dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .seed(seed_a),
    .puf(pa), .busy(busy_a), .done(done_a), .response(resp_a), .bit_count(bc_a)
  );

  puf_crp_engine #(.RESP_W(4), .SETTLE_CYC(0), .VOTES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .seed(seed_b),
    .puf(pb), .busy(busy_b), .done(done_b), .response(resp_b), .bit_count(bc_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference state gathered while a run on dut_a progresses
  logic [NV-1:0] vv [64];
  logic [63:0]   chal_obs [64];
  int            fires, done_cyc, chal_moves, cur_v, cur_b;

  function automatic logic [63:0] lfsr_step(input logic [63:0] x);
    return (x << 1) | 64'(^(x & TAPS));
  endfunction

  function automatic logic [63:0] model_resp(input int nbits);
    logic [63:0] r = '0;
    for (int b = 0; b < nbits; b++)
      r = (r << 1) | 64'($countones(vv[b]) > NV / 2);
    return r;
  endfunction

  function automatic int chal_errors(input logic [63:0] s, input int nbits);
    logic [63:0] e = (s == '0) ? 64'h1 : s;
    int bad = 0;
    for (int b = 0; b < nbits; b++) begin
      if (chal_obs[b] !== e) bad++;
      e = lfsr_step(e);
    end
    return bad;
  endfunction

  // Drives the response for the vote just launched and records it for the model
  task automatic record_fire(input int mode, input logic tie);
    logic r;
    if (cur_b < 64) begin
      if (cur_v == 0) chal_obs[cur_b] = pa.puf_challenge;
      else if (pa.puf_challenge !== chal_obs[cur_b]) chal_moves++;
      case (mode)
        0:       r = tie;
        1:       r = (cur_b % 2 == 0) ? (cur_v == 0 || cur_v == 1 || cur_v == 4)
                                      : (cur_v == 2 || cur_v == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      pa.puf_resp = r;
      vv[cur_b][cur_v] = r;
    end
    fires++;
    cur_v++;
    if (cur_v == NV) begin
      cur_v = 0;
      cur_b++;
    end
  endtask

  task automatic init_run();
    fires = 0; done_cyc = -1; chal_moves = 0; cur_v = 0; cur_b = 0;
  endtask

  task automatic run_a(input int mode, input logic [63:0] s, input logic tie);
    int c;
    init_run();
    @(negedge clk);
    seed_a = s; start_a = 1'b1; c = 0;
    while (c < FULL_LAT + 200 && done_cyc < 0) begin
      @(negedge clk);
      start_a = 1'b0;
      c++;
      if (pa.puf_fire) record_fire(mode, tie);
      if (done_a) done_cyc = c;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy_a !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_cmp++; if (done_a !== 1'b0)     begin n_err++; $display("FAIL reset_done: got %b want 0", done_a); end
    n_cmp++; if (resp_a !== 64'h0)    begin n_err++; $display("FAIL reset_response: got %h want 0", resp_a); end
    n_cmp++; if (bc_a !== 7'd0)       begin n_err++; $display("FAIL reset_bit_count: got %0d want 0", bc_a); end
    n_cmp++; if (pa.puf_fire !== 1'b0) begin n_err++; $display("FAIL reset_fire: got %b want 0", pa.puf_fire); end
    n_cmp++; if (pa.puf_challenge !== 64'h0) begin n_err++; $display("FAIL reset_challenge: got %h want 0", pa.puf_challenge); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_saturated_ones();
    logic [63:0] s = 64'h0123_4567_89AB_CDEF;
    int bad;
    run_a(0, s, 1'b1);
    n_cmp++; if (done_cyc != FULL_LAT) begin n_err++; $display("FAIL ones_latency: got %0d want %0d", done_cyc, FULL_LAT); end
    n_cmp++; if (fires != 320) begin n_err++; $display("FAIL ones_fire_count: got %0d want 320", fires); end
    n_cmp++; if (resp_a !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL ones_response: got %h want ffffffffffffffff", resp_a); end
    n_cmp++; if (bc_a !== 7'd64) begin n_err++; $display("FAIL ones_bit_count: got %0d want 64", bc_a); end
    n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL ones_busy_in_done: got %b want 1", busy_a); end
    bad = chal_errors(s, 64);
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL ones_challenge_seq: got %0d wrong want 0", bad); end
    n_cmp++; if (chal_moves != 0) begin n_err++; $display("FAIL ones_challenge_stable: got %0d moves want 0", chal_moves); end
    @(negedge clk);
    n_cmp++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin n_err++; $display("FAIL ones_after_done: got busy=%b done=%b want 0/0", busy_a, done_a); end
    repeat (10) @(negedge clk);
    n_cmp++; if (resp_a !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL ones_response_hold: got %h want ffffffffffffffff", resp_a); end
  endtask

  task automatic test_zero_seed();
    run_a(0, 64'h0, 1'b0);
    n_cmp++; if (resp_a !== 64'h0) begin n_err++; $display("FAIL zero_response: got %h want 0", resp_a); end
    n_cmp++; if (chal_obs[0] !== 64'h1) begin n_err++; $display("FAIL zero_chal0: got %h want 1", chal_obs[0]); end
    n_cmp++; if (chal_obs[1] !== 64'h2) begin n_err++; $display("FAIL zero_chal1: got %h want 2", chal_obs[1]); end
    n_cmp++; if (chal_obs[2] !== 64'h4) begin n_err++; $display("FAIL zero_chal2: got %h want 4", chal_obs[2]); end
    n_cmp++; if (done_cyc != FULL_LAT) begin n_err++; $display("FAIL zero_latency: got %0d want %0d", done_cyc, FULL_LAT); end
  endtask

  task automatic test_majority();
    logic [63:0] s = {$urandom, $urandom};
    int bad;
    run_a(1, s, 1'b0);
    n_cmp++; if (resp_a !== 64'hAAAA_AAAA_AAAA_AAAA) begin n_err++; $display("FAIL majority_response: got %h want aaaaaaaaaaaaaaaa", resp_a); end
    bad = chal_errors(s, 64);
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL majority_challenge_seq: got %0d wrong want 0", bad); end
  endtask

  task automatic test_random();
    logic [63:0] s = {$urandom, $urandom};
    logic [63:0] exp;
    int bad;
    run_a(2, s, 1'b0);
    exp = model_resp(64);
    n_cmp++; if (resp_a !== exp) begin n_err++; $display("FAIL random_response: got %h want %h", resp_a, exp); end
    bad = chal_errors(s, 64);
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL random_challenge_seq: got %0d wrong want 0", bad); end
    n_cmp++; if (chal_moves != 0) begin n_err++; $display("FAIL random_challenge_stable: got %0d moves want 0", chal_moves); end
  endtask

  task automatic test_small();
    logic [3:0] pat = 4'b1011;
    logic [63:0] s = {$urandom, $urandom};
    logic [63:0] e = (s == '0) ? 64'h1 : s;
    int c, k, dcyc, busy_bad, chal_bad;
    k = 0; dcyc = -1; busy_bad = 0; chal_bad = 0;
    @(negedge clk);
    seed_b = s; start_b = 1'b1; c = 0;
    while (c < 20) begin
      @(negedge clk);
      start_b = 1'b0;
      c++;
      if (busy_b !== ((c >= 1 && c <= 14) ? 1'b1 : 1'b0)) busy_bad++;
      if (pb.puf_fire) begin
        if (k < 4) begin
          if (pb.puf_challenge !== e) chal_bad++;
          e = lfsr_step(e);
          pb.puf_resp = pat[3 - k];
        end
        k++;
      end
      if (done_b && dcyc < 0) dcyc = c;
    end
    n_cmp++; if (dcyc != 14) begin n_err++; $display("FAIL small_done_cycle: got %0d want 14", dcyc); end
    n_cmp++; if (resp_b !== 64'hB) begin n_err++; $display("FAIL small_response: got %h want b", resp_b); end
    n_cmp++; if (bc_b !== 7'd4) begin n_err++; $display("FAIL small_bit_count: got %0d want 4", bc_b); end
    n_cmp++; if (busy_bad != 0) begin n_err++; $display("FAIL small_busy_window: got %0d bad cycles want 0", busy_bad); end
    n_cmp++; if (k != 4) begin n_err++; $display("FAIL small_fire_count: got %0d want 4", k); end
    n_cmp++; if (chal_bad != 0) begin n_err++; $display("FAIL small_challenge_seq: got %0d wrong want 0", chal_bad); end
  endtask

  task automatic test_abort();
    logic [63:0] exp;
    int c;
    bit done_seen = 0;
    init_run();
    @(negedge clk);
    seed_a = {$urandom, $urandom}; start_a = 1'b1; c = 0;
    while (c < 530) begin
      @(negedge clk);
      c++;
      start_a = (c == 100);
      abort_a = (c == 500);
      if (pa.puf_fire) record_fire(2, 1'b0);
      if (done_a) done_seen = 1;
      if (c == 501) begin
        exp = model_resp(5);
        n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy_a); end
        n_cmp++; if (bc_a !== 7'd5) begin n_err++; $display("FAIL abort_bit_count: got %0d want 5", bc_a); end
        n_cmp++; if (resp_a !== exp) begin n_err++; $display("FAIL abort_partial_response: got %h want %h", resp_a, exp); end
      end
    end
    n_cmp++; if (done_seen) begin n_err++; $display("FAIL abort_no_done: got 1 want 0"); end
    n_cmp++; if (busy_a !== 1'b0 || bc_a !== 7'd5) begin n_err++; $display("FAIL abort_idle_hold: got busy=%b bc=%0d want 0/5", busy_a, bc_a); end
    run_a(2, {$urandom, $urandom}, 1'b0);
    exp = model_resp(64);
    n_cmp++; if (done_cyc != FULL_LAT) begin n_err++; $display("FAIL abort_rerun_latency: got %0d want %0d", done_cyc, FULL_LAT); end
    n_cmp++; if (resp_a !== exp) begin n_err++; $display("FAIL abort_rerun_response: got %h want %h", resp_a, exp); end
  endtask

  task automatic test_reset_midrun();
    int c;
    bit late = 0;
    init_run();
    @(negedge clk);
    seed_a = {$urandom, $urandom}; start_a = 1'b1; c = 0;
    while (c < 1000) begin
      @(negedge clk);
      start_a = 1'b0;
      c++;
      if (pa.puf_fire) record_fire(0, 1'b1);
    end
    n_cmp++; if (resp_a === 64'h0) begin n_err++; $display("FAIL midrun_pre_response: got %h want nonzero", resp_a); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL midrun_busy: got %b want 0", busy_a); end
    n_cmp++; if (pa.puf_fire !== 1'b0) begin n_err++; $display("FAIL midrun_fire: got %b want 0", pa.puf_fire); end
    n_cmp++; if (resp_a !== 64'h0) begin n_err++; $display("FAIL midrun_response: got %h want 0", resp_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_err++; $display("FAIL midrun_done: got %b want 0", done_a); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (done_a || busy_a) late = 1;
    end
    n_cmp++; if (late) begin n_err++; $display("FAIL midrun_stays_idle: got activity want none"); end
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; seed_a = '0;
    start_b = 1'b0; abort_b = 1'b0; seed_b = '0;
    pa.puf_resp = 1'b0; pb.puf_resp = 1'b0;
    test_reset();
    test_small();
    test_saturated_ones();
    test_zero_seed();
    test_majority();
    test_random();
    test_abort();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
